// File: rtl/pix_fifo.sv
// pix_fifo: single-clock FIFO buffering {mode, proc_val, data} pixel words.
// Ports: clk, rst_n (async, active low), flush (sync clear);
//   write side slvx_mode/slvx_proc_val/slvx_data qualified by slvx_data_valid;
//   status fifo_full, almost_full, fifo_empty, fifo_cnt, ovf_err (sticky);
//   read side rd_en -> rd_valid + rd_mode/rd_proc_val/rd_data one cycle later.
module pix_fifo #(
  parameter int DW       = 32,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [1:0]               slvx_mode,
  input  logic                     slvx_data_valid,
  input  logic [7:0]               slvx_proc_val,
  input  logic [DW-1:0]            slvx_data,
  output logic                     fifo_full,
  output logic                     almost_full,
  output logic                     fifo_empty,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [1:0]               rd_mode,
  output logic [7:0]               rd_proc_val,
  output logic [DW-1:0]            rd_data,
  output logic                     ovf_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [1:0]    mode;
    logic [7:0]    proc_val;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;

  logic wr_acc;
  logic rd_acc;
  logic wr_drop;

  // Status flags come only from the registered count, so
  // accept decisions never loop through the request inputs.
  assign fifo_cnt    = cnt;
  assign fifo_full   = (cnt == CW'(DEPTH));
  assign fifo_empty  = (cnt == '0);
  assign almost_full = (cnt >= CW'(AF_LEVEL));

  assign wr_acc  = slvx_data_valid & ~fifo_full;
  assign rd_acc  = rd_en & ~fifo_empty;
  assign wr_drop = slvx_data_valid & fifo_full;

  // Storage has no reset; the zeroed pointers and count
  // keep any stale entry unreachable.
  always_ff @(posedge clk) begin
    if (wr_acc && !flush) begin
      mem[wr_ptr] <= '{mode:     slvx_mode,
                       proc_val: slvx_proc_val,
                       data:     slvx_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        (wr_acc && !rd_acc): cnt <= cnt + 1'b1;
        (rd_acc && !wr_acc): cnt <= cnt - 1'b1;
        default:             cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_err <= 1'b0;
    end else if (flush) begin
      ovf_err <= 1'b0;
    end else if (wr_drop) begin
      ovf_err <= 1'b1;
    end
  end

  // Read data registers hold across idle cycles and flush;
  // only rd_valid is cleared by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid    <= 1'b0;
      rd_mode     <= '0;
      rd_proc_val <= '0;
      rd_data     <= '0;
    end else if (flush) begin
      rd_valid    <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) begin
        rd_mode     <= mem[rd_ptr].mode;
        rd_proc_val <= mem[rd_ptr].proc_val;
        rd_data     <= mem[rd_ptr].data;
      end
    end
  end

endmodule

// File: tb/tb_pix_fifo.sv
// tb_pix_fifo: directed self-checking bench for pix_fifo
// (DW=32, DEPTH=8, AF_LEVEL=6).
module tb_pix_fifo;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [1:0]  slvx_mode;
  logic        slvx_data_valid;
  logic [7:0]  slvx_proc_val;
  logic [31:0] slvx_data;
  logic        fifo_full;
  logic        almost_full;
  logic        fifo_empty;
  logic [3:0]  fifo_cnt;
  logic        rd_en;
  logic        rd_valid;
  logic [1:0]  rd_mode;
  logic [7:0]  rd_proc_val;
  logic [31:0] rd_data;
  logic        ovf_err;

  int errors = 0;
  int checks = 0;

  pix_fifo #(.DW(32), .DEPTH(8), .AF_LEVEL(6)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .slvx_mode       (slvx_mode),
    .slvx_data_valid (slvx_data_valid),
    .slvx_proc_val   (slvx_proc_val),
    .slvx_data       (slvx_data),
    .fifo_full       (fifo_full),
    .almost_full     (almost_full),
    .fifo_empty      (fifo_empty),
    .fifo_cnt        (fifo_cnt),
    .rd_en           (rd_en),
    .rd_valid        (rd_valid),
    .rd_mode         (rd_mode),
    .rd_proc_val     (rd_proc_val),
    .rd_data         (rd_data),
    .ovf_err         (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic v, input logic [1:0] m,
                        input logic [7:0] pv, input logic [31:0] d);
    slvx_data_valid = v;
    slvx_mode       = m;
    slvx_proc_val   = pv;
    slvx_data       = d;
  endtask

  task automatic reset_vals(input string tag);
    check({tag, "_cnt"},   64'(fifo_cnt), 64'd0);
    check({tag, "_empty"}, 64'(fifo_empty), 64'd1);
    check({tag, "_full"},  64'(fifo_full), 64'd0);
    check({tag, "_af"},    64'(almost_full), 64'd0);
    check({tag, "_ovf"},   64'(ovf_err), 64'd0);
    check({tag, "_rdv"},   64'(rd_valid), 64'd0);
    check({tag, "_rdm"},   64'(rd_mode), 64'd0);
    check({tag, "_rdpv"},  64'(rd_proc_val), 64'd0);
    check({tag, "_rdd"},   64'(rd_data), 64'd0);
  endtask

  initial begin
    logic [31:0] exp_d [8];
    logic [1:0]  exp_m [8];
    logic [7:0]  exp_p [8];

    rst_n = 1'b0;
    flush = 1'b0;
    rd_en = 1'b0;
    set_wr(1'b0, 2'd0, 8'h00, 32'h0);
    #12;
    reset_vals("rst");
    rst_n = 1'b1;

    // three words in, three out in order
    for (int i = 1; i <= 3; i++) begin
      set_wr(1'b1, 2'd0, 8'hFF, 32'(i));
      tick();
    end
    set_wr(1'b0, 2'd0, 8'h00, 32'h0);
    check("w3_cnt", 64'(fifo_cnt), 64'd3);
    check("w3_empty", 64'(fifo_empty), 64'd0);
    rd_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("r3_valid", 64'(rd_valid), 64'd1);
      check("r3_data", 64'(rd_data), 64'(i));
      check("r3_pv", 64'(rd_proc_val), 64'hFF);
      check("r3_cnt", 64'(fifo_cnt), 64'(3 - i));
    end
    check("r3_empty", 64'(fifo_empty), 64'd1);
    rd_en = 1'b0;
    tick();
    check("idle_valid", 64'(rd_valid), 64'd0);
    check("idle_hold", 64'(rd_data), 64'd3);

    // fill to full, overflow attempt
    for (int i = 0; i < 8; i++) begin
      set_wr(1'b1, 2'(i), 8'(8'h10 + i), 32'(32'h10 + i));
      tick();
      check("fill_cnt", 64'(fifo_cnt), 64'(i + 1));
      check("fill_af", 64'(almost_full), 64'(i + 1 >= 6));
      check("fill_full", 64'(fifo_full), 64'(i + 1 == 8));
    end
    check("pre_ovf", 64'(ovf_err), 64'd0);
    set_wr(1'b1, 2'd3, 8'hAA, 32'hDEADBEEF);
    tick();
    set_wr(1'b0, 2'd0, 8'h00, 32'h0);
    check("ovf_set", 64'(ovf_err), 64'd1);
    check("ovf_cnt", 64'(fifo_cnt), 64'd8);

    // drain 4, refill 4 across the wrap, drain 8
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("d4_data", 64'(rd_data), 64'(32'h10 + i));
      check("d4_mode", 64'(rd_mode), 64'(i % 4));
      check("d4_pv", 64'(rd_proc_val), 64'(8'h10 + i));
    end
    rd_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_wr(1'b1, 2'(3 - i), 8'(8'hC0 + i), 32'(32'h20 + i));
      tick();
    end
    set_wr(1'b0, 2'd0, 8'h00, 32'h0);
    check("wrap_full", 64'(fifo_full), 64'd1);
    for (int i = 0; i < 4; i++) begin
      exp_d[i]     = 32'(32'h14 + i);
      exp_m[i]     = 2'(4 + i);
      exp_p[i]     = 8'(8'h14 + i);
      exp_d[i + 4] = 32'(32'h20 + i);
      exp_m[i + 4] = 2'(3 - i);
      exp_p[i + 4] = 8'(8'hC0 + i);
    end
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("d8_valid", 64'(rd_valid), 64'd1);
      check("d8_data", 64'(rd_data), 64'(exp_d[i]));
      check("d8_mode", 64'(rd_mode), 64'(exp_m[i]));
      check("d8_pv", 64'(rd_proc_val), 64'(exp_p[i]));
    end
    rd_en = 1'b0;
    check("d8_empty", 64'(fifo_empty), 64'd1);
    check("d8_ovf", 64'(ovf_err), 64'd1);

    // write into empty with concurrent rd_en
    rd_en = 1'b1;
    set_wr(1'b1, 2'd2, 8'h5A, 32'h0000_0077);
    tick();
    set_wr(1'b0, 2'd0, 8'h00, 32'h0);
    check("we_valid", 64'(rd_valid), 64'd0);
    check("we_cnt", 64'(fifo_cnt), 64'd1);
    tick();
    check("we_rvalid", 64'(rd_valid), 64'd1);
    check("we_data", 64'(rd_data), 64'h77);
    check("we_mode", 64'(rd_mode), 64'd2);
    rd_en = 1'b0;

    // steady state at cnt=4 with write+read every cycle
    for (int i = 0; i < 4; i++) begin
      set_wr(1'b1, 2'd1, 8'h0F, 32'(32'h30 + i));
      tick();
    end
    check("ss_cnt0", 64'(fifo_cnt), 64'd4);
    rd_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_wr(1'b1, 2'd1, 8'h0F, 32'(32'h34 + i));
      tick();
      check("ss_cnt", 64'(fifo_cnt), 64'd4);
      check("ss_data", 64'(rd_data), 64'(32'h30 + i));
    end
    set_wr(1'b0, 2'd0, 8'h00, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ss_drain", 64'(rd_data), 64'(32'h3A + i));
    end
    tick();
    check("re_valid", 64'(rd_valid), 64'd0);
    check("re_cnt", 64'(fifo_cnt), 64'd0);
    check("re_hold", 64'(rd_data), 64'h3D);
    check("re_ovf", 64'(ovf_err), 64'd1);
    rd_en = 1'b0;

    // flush at cnt=5 with ovf set and concurrent write+read
    for (int i = 0; i < 5; i++) begin
      set_wr(1'b1, 2'd0, 8'h33, 32'(32'h50 + i));
      tick();
    end
    check("fl_cnt5", 64'(fifo_cnt), 64'd5);
    flush = 1'b1;
    rd_en = 1'b1;
    set_wr(1'b1, 2'd0, 8'h33, 32'h0000_0099);
    tick();
    flush = 1'b0;
    rd_en = 1'b0;
    set_wr(1'b0, 2'd0, 8'h00, 32'h0);
    check("fl_cnt", 64'(fifo_cnt), 64'd0);
    check("fl_ovf", 64'(ovf_err), 64'd0);
    check("fl_valid", 64'(rd_valid), 64'd0);
    check("fl_empty", 64'(fifo_empty), 64'd1);
    check("fl_hold", 64'(rd_data), 64'h3D);
    set_wr(1'b1, 2'd3, 8'h01, 32'h0000_00AB);
    tick();
    set_wr(1'b0, 2'd0, 8'h00, 32'h0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("fl_rd", 64'(rd_data), 64'hAB);
    check("fl_rdm", 64'(rd_mode), 64'd3);

    // async reset mid-cycle at cnt=6
    tick();
    for (int i = 0; i < 6; i++) begin
      set_wr(1'b1, 2'd1, 8'h77, 32'(32'h60 + i));
      tick();
    end
    set_wr(1'b0, 2'd0, 8'h00, 32'h0);
    check("ar_cnt6", 64'(fifo_cnt), 64'd6);
    check("ar_af", 64'(almost_full), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    reset_vals("arst");
    #1;
    rst_n = 1'b1;
    set_wr(1'b1, 2'd2, 8'h42, 32'hCAFE_0001);
    tick();
    set_wr(1'b0, 2'd0, 8'h00, 32'h0);
    check("ar_wcnt", 64'(fifo_cnt), 64'd1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("ar_valid", 64'(rd_valid), 64'd1);
    check("ar_data", 64'(rd_data), 64'hCAFE_0001);
    check("ar_pv", 64'(rd_proc_val), 64'h42);
    check("ar_empty", 64'(fifo_empty), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pix_fifo.md
PIX_FIFO -- requirements
Module: pix_fifo

Interface
REQ-001 Parameter DW, default 32, pixel data word width.
REQ-002 Parameter DEPTH, default 8, entry count; SHALL be a power of 2, minimum 4.
REQ-003 Parameter AF_LEVEL, default 6, almost-full threshold in entries (1..DEPTH-1).
REQ-004 Ports SHALL be:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of FIFO contents
- slvx_mode  in  2  mode tag of incoming word
- slvx_data_valid  in  1  write strobe
- slvx_proc_val  in  8  per-byte processing-valid mask
- slvx_data  in  DW  incoming pixel word
- fifo_full  out  1  no free entry
- almost_full  out  1  count >= AF_LEVEL
- fifo_empty  out  1  no stored entry
- fifo_cnt  out  log2(DEPTH)+1  stored entries
- rd_en  in  1  read request from downstream master
- rd_valid  out  1  rd_* outputs carry a fresh entry this cycle
- rd_mode  out  2  mode of popped entry
- rd_proc_val  out  8  mask of popped entry
- rd_data  out  DW  data of popped entry
- ovf_err  out  1  sticky: write attempted while full

Function
REQ-005 Each entry SHALL store {mode, proc_val, data} (DW+10 bits) as one unit; fields SHALL never be split across entries.
REQ-006 Write accepted when slvx_data_valid=1 and fifo_full=0 (registered value, same cycle); entry written at wr_ptr; wr_ptr increments modulo DEPTH.
REQ-007 slvx_data_valid=1 while fifo_full=1 SHALL drop the word, leave pointers/count unchanged, and set ovf_err on the next edge.
REQ-008 ovf_err SHALL stay 1 until rst_n low or flush=1.
REQ-009 Read accepted when rd_en=1 and fifo_empty=0; entry at rd_ptr loaded into rd_mode/rd_proc_val/rd_data on that edge; rd_ptr increments modulo DEPTH.
REQ-010 rd_valid SHALL be 1 for exactly one cycle after each accepted read (1-cycle read latency), else 0.
REQ-011 rd_en=1 while fifo_empty=1 SHALL be ignored: rd_valid=0, pointers unchanged, no error flag.
REQ-012 rd_mode/rd_proc_val/rd_data SHALL hold their last value when no read is accepted.
REQ-013 Accepted write and read in the same cycle: count unchanged; both pointers advance.
REQ-014 Write into empty FIFO with simultaneous rd_en: write accepted, read ignored (fifo_empty evaluated on the registered count); data readable from the next cycle.
REQ-015 fifo_cnt SHALL equal accepted writes minus accepted reads since last reset/flush, range 0..DEPTH.
REQ-016 fifo_full = (fifo_cnt == DEPTH); fifo_empty = (fifo_cnt == 0); almost_full = (fifo_cnt >= AF_LEVEL); all derived from registered count, no combinational path from slvx_data_valid or rd_en.
REQ-017 Pointers SHALL wrap from DEPTH-1 to 0 with no data loss across the wrap.
REQ-018 flush=1 SHALL take priority over same-cycle read and write: next cycle pointers=0, fifo_cnt=0, ovf_err=0, rd_valid=0; rd_* data fields hold; the concurrent write is discarded.

Reset
REQ-019 rst_n low SHALL asynchronously force: wr_ptr=0, rd_ptr=0, fifo_cnt=0, fifo_empty=1, fifo_full=0, almost_full=0, ovf_err=0, rd_valid=0, rd_mode=0, rd_proc_val=0, rd_data=0.
REQ-020 Storage array contents need not be reset; no stale entry SHALL be readable after reset.
REQ-021 rst_n assertion mid-operation SHALL discard all entries; first write after deassertion lands at index 0.
REQ-022 rst_n deassertion is synchronised externally; block SHALL accept writes on the first edge with rst_n high.

Verification
REQ-023 Reset, write 3 words (mode 0, proc_val FF, data 00000001/2/3), then rd_en 3 cycles -> rd_valid pulses 3 cycles, data 1,2,3 in order, fifo_cnt 3->0, fifo_empty=1 at end.
REQ-024 Write 8 words without reading -> almost_full=1 at cnt 6, fifo_full=1 at cnt 8; 9th write (data DEADBEEF) dropped, ovf_err=1; reading 8 returns no DEADBEEF.
REQ-025 Full FIFO, drain 4, write 4 more, drain 8 -> order preserved across pointer wrap, mode/proc_val fields match each word.
REQ-026 cnt=4, simultaneous write+read for 10 cycles -> fifo_cnt stays 4, rd data sequential; rd_en on empty FIFO -> rd_valid=0, ovf_err unchanged.
REQ-027 cnt=5 with ovf_err=1, assert flush with concurrent write and read -> next cycle cnt=0, ovf_err=0, rd_valid=0, fifo_empty=1.
REQ-028 rst_n pulsed low asynchronously (mid-cycle) at cnt=6 -> all outputs at REQ-019 values immediately; next write then read returns that write's data.
